// File: rtl/rom_fetch_pkg.sv
// Shared types and default widths for the ROM fetch sequencer.
// The optional checksum output is enabled by defining FETCH_CHECKSUM_EN.
package rom_fetch_pkg;

   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 4;
   localparam int ROM_DEPTH  = 2 ** DEF_ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry valid/ready buffer; slot 0 is the registered output stage.
module fetch_skid_fifo
   import rom_fetch_pkg::*;
#(
   parameter int W = DEF_DATA_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [1:0]   count
);

   logic         v0_q, v0_d, v1_q, v1_d;
   logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
   logic         pop_s;

   // Next-state: shift on pop, then place an incoming word in the first free slot
   always_comb begin
      pop_s = v0_q & out_ready;
      if (pop_s) begin
         v0_d = v1_q;
         d0_d = v1_q ? d1_q : d0_q;
         v1_d = 1'b0;
         d1_d = d1_q;
      end else begin
         v0_d = v0_q;
         d0_d = d0_q;
         v1_d = v1_q;
         d1_d = d1_q;
      end
      if (in_valid && !v0_d) begin
         v0_d = 1'b1;
         d0_d = in_data;
      end else if (in_valid) begin
         v1_d = 1'b1;
         d1_d = in_data;
      end else begin
         v1_d = v1_d;
      end
   end

   // Buffer storage with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v0_q <= 1'b0;
         v1_q <= 1'b0;
         d0_q <= '0;
         d1_q <= '0;
      end else begin
         v0_q <= v0_d;
         v1_q <= v1_d;
         d0_q <= d0_d;
         d1_q <= d1_d;
      end
   end

   assign out_valid = v0_q;
   assign out_data  = d0_q;
   assign count     = {1'b0, v0_q} + {1'b0, v1_q};

endmodule

// File: rtl/rom_fetch_seq.sv
// Sequential ROM read initiator streaming words over valid/ready.
// Define FETCH_CHECKSUM_EN to add the csum output (sum of accepted words).
module rom_fetch_seq
   import rom_fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  word_cnt,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
`ifdef FETCH_CHECKSUM_EN
   output logic [DATA_W-1:0] csum,
`endif
   output logic              done
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              infl_v_q, infl_v_d;
   logic [DATA_W-1:0] infl_data_q, infl_data_d;
   logic              infl_last_q, infl_last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W:0]   fifo_out_s;
   logic [1:0]        fifo_cnt_s;
   logic              fifo_valid_s;
   logic              pop_s;
   logic [2:0]        occ_after_s;
   logic              slot_free_s;
`ifdef FETCH_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   fetch_skid_fifo #(.W(DATA_W + 1)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (infl_v_q),
      .in_data   ({infl_last_q, infl_data_q}),
      .out_valid (fifo_valid_s),
      .out_data  (fifo_out_s),
      .out_ready (out_ready),
      .count     (fifo_cnt_s)
   );

   // A pop in the same cycle frees a slot, which keeps the stream at one word per cycle
   always_comb begin
      pop_s       = fifo_valid_s & out_ready;
      occ_after_s = {1'b0, fifo_cnt_s} + {2'b00, infl_v_q} - {2'b00, pop_s};
      slot_free_s = (occ_after_s < 3'd2);
   end

   // Sequencer next-state; the word on rom_data is captured into the in-flight stage when issued
   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      remaining_d = remaining_q;
      infl_v_d    = 1'b0;
      infl_data_d = infl_data_q;
      infl_last_d = infl_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef FETCH_CHECKSUM_EN
      csum_d      = pop_s ? (csum_q + fifo_out_s[DATA_W-1:0]) : csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && (word_cnt != '0)) begin
               rom_addr_d  = start_addr;
               remaining_d = word_cnt;
               state_d     = ISSUE;
               busy_d      = 1'b1;
`ifdef FETCH_CHECKSUM_EN
               csum_d      = '0;
`endif
            end else if (start) begin
               done_d      = 1'b1;
`ifdef FETCH_CHECKSUM_EN
               csum_d      = '0;
`endif
            end else begin
               state_d     = IDLE;
            end
         end
         ISSUE: begin
            if ((remaining_q != '0) && slot_free_s) begin
               infl_v_d    = 1'b1;
               infl_data_d = rom_data;
               infl_last_d = (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1});
               rom_addr_d  = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
               state_d     = infl_last_d ? DRAIN : ISSUE;
            end else begin
               state_d     = ISSUE;
            end
         end
         DRAIN: begin
            if (pop_s && fifo_out_s[DATA_W]) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rom_addr_q  <= '0;
         remaining_q <= '0;
         infl_v_q    <= 1'b0;
         infl_data_q <= '0;
         infl_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef FETCH_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         remaining_q <= remaining_d;
         infl_v_q    <= infl_v_d;
         infl_data_q <= infl_data_d;
         infl_last_q <= infl_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef FETCH_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign rom_addr  = rom_addr_q;
   assign out_valid = fifo_valid_s;
   assign out_data  = fifo_out_s[DATA_W-1:0];
   assign out_last  = fifo_out_s[DATA_W];
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef FETCH_CHECKSUM_EN
   assign csum      = csum_q;
`endif

endmodule
